// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg: op/state encodings and divide corner-case constants for mdu_iter.
// Rev 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam int MDU_MAX_W = 64;

  typedef enum logic [2:0] {
    OP_MULTU = 3'b000,
    OP_MULT  = 3'b001,
    OP_DIVU  = 3'b010,
    OP_DIV   = 3'b011,
    OP_MADDU = 3'b100,
    OP_MADD  = 3'b101,
    OP_MSUBU = 3'b110,
    OP_MSUB  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  // LO after a divide by zero; callers truncate to their width.
  function automatic logic [MDU_MAX_W-1:0] div_zero_lo();
    return '1;
  endfunction

  // HI after the signed most-negative / -1 overflow.
  function automatic logic [MDU_MAX_W-1:0] div_ovf_hi();
    return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iter_step.sv
// ============================================================================
// mdu_iter_step: one radix-2 step (shift-add multiply or restoring divide).
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_mode_div,
  input  logic [2*WIDTH:0]   i_part,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH:0]   o_part,
  output logic               o_qbit
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_trial;

  always_comb begin
    w_sum    = i_part[2*WIDTH:WIDTH] + (i_part[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    w_rem_sh = i_part[2*WIDTH-1:WIDTH-1];
    w_trial  = {1'b0, w_rem_sh} - {2'b00, i_opnd};
    o_qbit   = 1'b0;
    o_part   = {1'b0, w_sum, i_part[WIDTH-1:1]};
    if (i_mode_div) begin
      // Quotient bit is returned separately; the LSB slot is left clear for it.
      o_qbit = ~w_trial[WIDTH+1];
      o_part = {(o_qbit ? w_trial[WIDTH:0] : w_rem_sh), i_part[WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// mdu_iter: iterative multiply/divide unit with HI/LO; define MDU_MACC_EN
// to enable MADD/MADDU/MSUB/MSUBU accumulation.  Rev 1.0
// ============================================================================
`default_nettype none

module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int             CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

  mdu_state_e         r_state;
  mdu_state_e         w_next_state;
  logic               w_load;
  logic               w_step;
  logic               w_commit;
  logic               w_wr_ok;

  logic [2*WIDTH:0]   r_part;
  logic [WIDTH-1:0]   r_opnd;
  logic [CW-1:0]      r_cnt;
  mdu_op_e            r_op;
  logic [WIDTH-1:0]   r_a;
  logic               r_b_zero;
  logic               r_ovf;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  mdu_op_e            w_op_in;
  logic               w_div_in;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH:0]   w_step_part;
  logic               w_qbit;

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_CALC;
      ST_CALC: begin
        if (cancel)                  w_next_state = ST_IDLE;
        else if (r_cnt == LAST_ITER) w_next_state = ST_FIX;
      end
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    w_load   = (r_state == ST_IDLE) && start;
    w_wr_ok  = (r_state == ST_IDLE) && !start;
    w_step   = (r_state == ST_CALC) && !cancel;
    w_commit = (r_state == ST_FIX)  && !cancel;
  end

  // Signed ops iterate on magnitudes; signs are reapplied in FIX.
  always_comb begin
    w_op_in  = mdu_op_e'(op);
    w_div_in = is_div_op(w_op_in);
    w_a_neg  = op[0] & a[WIDTH-1];
    w_b_neg  = op[0] & b[WIDTH-1];
    w_a_mag  = w_a_neg ? -a : a;
    w_b_mag  = w_b_neg ? -b : b;
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_mode_div (is_div_op(r_op)),
    .i_part     (r_part),
    .i_opnd     (r_opnd),
    .o_part     (w_step_part),
    .o_qbit     (w_qbit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_part   <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_op     <= OP_MULTU;
      r_a      <= '0;
      r_b_zero <= 1'b0;
      r_ovf    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_load) begin
      r_part   <= {{(WIDTH+1){1'b0}}, (w_div_in ? w_a_mag : w_b_mag)};
      r_opnd   <= w_div_in ? w_b_mag : w_a_mag;
      r_cnt    <= '0;
      r_op     <= w_op_in;
      r_a      <= a;
      r_b_zero <= (b == '0);
      r_ovf    <= (w_op_in == OP_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
    end else if (w_step) begin
      r_part   <= w_step_part | {{(2*WIDTH){1'b0}}, w_qbit};
      r_cnt    <= r_cnt + 1'b1;
    end
  end

`ifdef MDU_MACC_EN
  logic [2*WIDTH-1:0] r_snap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_snap <= '0;
    else if (w_load) r_snap <= {r_hi, r_lo};
  end
`endif

  always_comb begin
    w_prod    = r_neg_q ? -r_part[2*WIDTH-1:0] : r_part[2*WIDTH-1:0];
    w_mul_res = w_prod;
`ifdef MDU_MACC_EN
    if (r_op[2]) w_mul_res = r_op[1] ? (r_snap - w_prod) : (r_snap + w_prod);
`endif
    w_quot = r_neg_q ? -r_part[WIDTH-1:0] : r_part[WIDTH-1:0];
    w_rem  = r_neg_r ? -r_part[2*WIDTH-1:WIDTH] : r_part[2*WIDTH-1:WIDTH];
    if (is_div_op(r_op)) begin
      if (r_b_zero) begin
        w_fix_hi = r_a;
        w_fix_lo = WIDTH'(div_zero_lo());
      end else if (r_ovf) begin
        w_fix_hi = WIDTH'(div_ovf_hi());
        w_fix_lo = r_a;
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quot;
      end
    end else begin
      w_fix_hi = w_mul_res[2*WIDTH-1:WIDTH];
      w_fix_lo = w_mul_res[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end else if (w_wr_ok) begin
      if (hi_we) r_hi <= a;
      if (lo_we) r_lo <= a;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// tb_mdu_iter: directed self-checking bench for mdu_iter (WIDTH=32).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic        cancel = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .start   (start),
    .op      (op),
    .cancel  (cancel),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue an op in the current cycle and count busy cycles until it drops.
  task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input string tag);
    int n;
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_latency"}, n, 33);
  endtask

  task automatic write_hl(input logic h, input logic l, input logic [31:0] v);
    hi_we = h; lo_we = l; a = v;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b001, 32'hFFFF_FFFF, 32'h2, "mult");
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    run_op(3'b000, 32'hFFFF_FFFF, 32'h2, "multu");
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    run_op(3'b001, 32'hFFFF_FFFD, 32'h5, "mult2");
    check("mult2_hi", hi, 32'hFFFF_FFFF);
    check("mult2_lo", lo, 32'hFFFF_FFF1);

    run_op(3'b011, 32'hFFFF_FFF9, 32'h2, "div");
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    run_op(3'b011, 32'h7, 32'hFFFF_FFFE, "div2");
    check("div2_lo", lo, 32'hFFFF_FFFD);
    check("div2_hi", hi, 32'h1);
    run_op(3'b010, 32'd100, 32'd7, "divu");
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    run_op(3'b010, 32'd5, 32'd0, "divu0");
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h5);
    run_op(3'b011, 32'hFFFF_FFF9, 32'd0, "div0");
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'hFFFF_FFF9);
    run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);

    // Cancel in IDLE must not block a same-cycle start.
    cancel = 1'b1;
    run_op(3'b000, 32'd6, 32'd7, "idlecancel");
    check("idlecancel_hi", hi, 32'h0);
    check("idlecancel_lo", lo, 32'd42);

    // Start wins over simultaneous writes.
    hi_we = 1'b1; lo_we = 1'b1;
    run_op(3'b000, 32'd2, 32'd3, "startwr");
    check("startwr_hi", hi, 32'h0);
    check("startwr_lo", lo, 32'd6);

    write_hl(1'b0, 1'b1, 32'hFFFF_FFFF);
    check("wr_lo", lo, 32'hFFFF_FFFF);
    write_hl(1'b1, 1'b0, 32'h0);
    check("wr_hi", hi, 32'h0);
    run_op(3'b100, 32'd1, 32'd1, "maddu");
`ifdef MDU_MACC_EN
    check("maddu_hi", hi, 32'h1);
    check("maddu_lo", lo, 32'h0);
`else
    check("maddu_hi", hi, 32'h0);
    check("maddu_lo", lo, 32'h1);
`endif
    run_op(3'b110, 32'd1, 32'd1, "msubu");
`ifdef MDU_MACC_EN
    check("msubu_hi", hi, 32'h0);
    check("msubu_lo", lo, 32'hFFFF_FFFF);
`else
    check("msubu_hi", hi, 32'h0);
    check("msubu_lo", lo, 32'h1);
`endif

    // Busy rules: ignored start/write, then cancel mid-calculation.
    write_hl(1'b1, 1'b1, 32'h1111_1111);
    check("wrboth_hi", hi, 32'h1111_1111);
    check("wrboth_lo", lo, 32'h1111_1111);
    op = 3'b000; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = 3'b010; hi_we = 1'b1; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("busy_mid", {31'b0, busy}, 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy", {31'b0, busy}, 32'd0);
    check("cancel_hi", hi, 32'h1111_1111);
    check("cancel_lo", lo, 32'h1111_1111);
    repeat (3) begin @(posedge clk); #1; end
    check("cancel_stays_idle", {31'b0, busy}, 32'd0);
    check("cancel_hi_late", hi, 32'h1111_1111);

    // Asynchronous reset mid-divide.
    op = 3'b010; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #2;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "postrst");
    check("postrst_hi", hi, 32'h0);
    check("postrst_lo", lo, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
